// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory fetch channel: word request/acknowledge between fetch unit and imem.
interface instr_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// PC register and fetch sequencer feeding the single-cycle decoder; one instruction is
// fetched (REQ), then held for execution (EXEC) until the next PC is committed.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   instr_fetch_unit_if.master         imem,
   output logic [31:0]                Instr,
   output logic [5:0]                 OpCode,
   output logic [5:0]                 Funct,
   output logic [31:0]                PC,
   output logic [31:0]                PC_plus4,
   output logic                       instr_valid,
   input  logic [1:0]                 PCSrc,
   input  logic                       Branch,
   input  logic                       Zero,
   input  logic [31:0]                jr_target,
   input  logic                       stall,
   output logic                       fetch_err
);

   // Counter only ever holds 0..TIMEOUT_CYCLES-1.
   localparam int unsigned    CntW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StExec,
      StErr
   } fetchStateT;

   fetchStateT     stateQ, stateD;
   logic [31:0]    pcQ, pcD;
   logic [31:0]    instrQ, instrD;
   logic [CntW-1:0] cntQ, cntD;
   logic [31:0]    pcPlus4;
   logic [31:0]    branchOff;
   logic [31:0]    nextPc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateQ <= StIdle;
         pcQ    <= RESET_PC;
         instrQ <= 32'h0000_0000;
         cntQ   <= '0;
      end else begin
         stateQ <= stateD;
         pcQ    <= pcD;
         instrQ <= instrD;
         cntQ   <= cntD;
      end
   end

   assign pcPlus4   = pcQ + 32'd4;
   assign branchOff = {{14{instrQ[15]}}, instrQ[15:0], 2'b00};

   always_comb begin
      nextPc = pcPlus4;
      case (PCSrc)
         2'b01:   nextPc = {pcPlus4[31:28], instrQ[25:0], 2'b00};
         2'b10:   nextPc = jr_target;
         2'b00:   if (Branch && Zero) nextPc = pcPlus4 + branchOff;
         default: nextPc = pcPlus4;
      endcase
   end

   always_comb begin
      stateD = stateQ;
      pcD    = pcQ;
      instrD = instrQ;
      cntD   = cntQ;
      case (stateQ)
         StIdle: stateD = StReq;
         StReq: begin
            if (imem.imem_ack) begin
               instrD = imem.imem_rdata;
               cntD   = '0;
               stateD = StExec;
            end else if (cntQ == CntLast) begin
               stateD = StErr;
            end else begin
               cntD = cntQ + 1'b1;
            end
         end
         StExec: begin
            if (!stall) begin
               // A misaligned target never reaches the PC; the error state keeps the old one.
               if (nextPc[1:0] != 2'b00) begin
                  stateD = StErr;
               end else begin
                  pcD    = nextPc;
                  stateD = StReq;
               end
            end
         end
         StErr:   stateD = StErr;
         default: stateD = StErr;
      endcase
   end

   assign imem.imem_req  = (stateQ == StReq);
   assign imem.imem_addr = pcQ;
   assign instr_valid    = (stateQ == StExec);
   assign fetch_err      = (stateQ == StErr);
   assign Instr          = instrQ;
   assign OpCode         = instrQ[31:26];
   assign Funct          = instrQ[5:0];
   assign PC             = pcQ;
   assign PC_plus4       = pcPlus4;

endmodule
